// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundle of the load/store sequencer's core-side request and
// response channels plus the data-memory read and write ports.
//   req_*      : request channel from the memory stage (valid/ready)
//   resp_*     : response channel back to the memory stage (valid/ready)
//   mem_rd_*   : single-cycle read port, data returned the cycle after enable
//   mem_wr_*   : write port, full word written on the enabling edge
// Modports:
//   slave  : the view used by lsu_ctrl itself
//   master : the view used by whatever drives requests and models memory
interface lsu_ctrl_if #(
  parameter int XLEN = 64,
  parameter int MA_W = 11
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  logic            mem_rd_en;
  logic [MA_W-1:0] mem_rd_addr;
  logic [3:0]      mem_rd_len;
  logic [XLEN-1:0] mem_rd_data;

  logic            mem_wr_en;
  logic [MA_W-1:0] mem_wr_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic [3:0]      mem_wr_len;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd_en, mem_rd_addr, mem_rd_len,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd_en, mem_rd_addr, mem_rd_len,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core memory stage and a
// 64-bit-word data memory. Handles one byte-addressed RV64 load or store at a
// time, does read-modify-write for sub-doubleword stores and returns
// sign/zero-extended load data or an error response.
// Ports:
//   clk : clock, everything on posedge
//   rst : synchronous active-high reset
//   bus : lsu_ctrl_if.slave (request, response, memory read/write ports)
module lsu_ctrl #(
  parameter int XLEN      = 64,
  parameter int MEM_WORDS = 2048,
  parameter int MA_W      = $clog2(MEM_WORDS)
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]      state;
  logic            lat_we;
  logic [2:0]      lat_f3;
  logic [2:0]      lat_off;
  logic [MA_W-1:0] lat_idx;
  logic [XLEN-1:0] lat_wdata;
  logic [XLEN-1:0] merge_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [2:0]      req_align;
  logic            req_err;
  logic            req_is_sd;
  logic [5:0]      shamt;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] merged;
  logic [3:0]      lat_len;

  // req_align holds the low address bits that must be zero for the size.
  always_comb begin
    case (bus.req_funct3[1:0])
      2'd0:    req_align = 3'b000;
      2'd1:    req_align = 3'b001;
      2'd2:    req_align = 3'b011;
      default: req_align = 3'b111;
    endcase
    req_err = (|(bus.req_addr[2:0] & req_align))
           || (|bus.req_addr[XLEN-1:MA_W+3])
           || (bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111));
    req_is_sd = bus.req_we && (bus.req_funct3[1:0] == 2'b11);
  end

  // Byte-lane extraction for loads and byte-lane replacement for stores,
  // both working on the word returned by the memory in MERGE.
  always_comb begin
    shamt = {lat_off, 3'b000};
    case (lat_f3[1:0])
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    field = bus.mem_rd_data >> shamt;
    case (lat_f3[1:0])
      2'd0:    load_ext = lat_f3[2] ? {56'b0, field[7:0]}  : {{56{field[7]}},  field[7:0]};
      2'd1:    load_ext = lat_f3[2] ? {48'b0, field[15:0]} : {{48{field[15]}}, field[15:0]};
      2'd2:    load_ext = lat_f3[2] ? {32'b0, field[31:0]} : {{32{field[31]}}, field[31:0]};
      default: load_ext = field;
    endcase
    merged  = (bus.mem_rd_data & ~(size_mask << shamt)) | ((lat_wdata & size_mask) << shamt);
    lat_len = 4'b0001 << lat_f3[1:0];
  end

  // Sequencer. The store data is parked in merge_q at acceptance so that a
  // full doubleword store can go straight to WRITE without a merge step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_off   <= 3'd0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      merge_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_f3    <= bus.req_funct3;
            lat_off   <= bus.req_addr[2:0];
            lat_idx   <= bus.req_addr[MA_W+2:3];
            lat_wdata <= bus.req_wdata;
            merge_q   <= bus.req_wdata;
            rdata_q   <= '0;
            err_q     <= req_err;
            if (req_err)        state <= S_RESP;
            else if (req_is_sd) state <= S_WRITE;
            else                state <= S_READ;
          end
        end
        S_READ:  state <= S_MERGE;
        S_MERGE: begin
          if (lat_we) begin
            merge_q <= merged;
            state   <= S_WRITE;
          end else begin
            rdata_q <= load_ext;
            state   <= S_RESP;
          end
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  if (bus.resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and are forced to their idle values while rst
  // is high, so a write or response cannot leak out in the reset cycle.
  always_comb begin
    bus.req_ready   = rst || (state == S_IDLE);
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = '0;
    bus.resp_err    = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_rd_len  = 4'd0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_len  = 4'd0;
    if (!rst) begin
      case (state)
        S_READ: begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = lat_idx;
          bus.mem_rd_len  = lat_len;
        end
        S_WRITE: begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_addr = lat_idx;
          bus.mem_wr_data = merge_q;
          bus.mem_wr_len  = lat_len;
        end
        S_RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = rdata_q;
          bus.resp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. A word memory answers the
// DUT's ports; a byte-addressed reference memory predicts every response.
module tb_lsu_ctrl;
  localparam int         MA_W   = 11;
  localparam int         WORDS  = 2048;
  localparam int         NBYTES = 16384;
  localparam logic [63:0] BYTES = 64'd16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.XLEN(64), .MA_W(MA_W)) bus();

  lsu_ctrl #(.XLEN(64), .MEM_WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Word memory seen by the DUT, plus a preload path from the bench
  logic [63:0]     tb_mem [WORDS];
  logic            pre_en;
  logic [MA_W-1:0] pre_idx;
  logic [63:0]     pre_data;

  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_idx] <= pre_data;
    if (bus.mem_wr_en) tb_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= tb_mem[bus.mem_rd_addr];
  end

  logic [7:0] ref_bytes [NBYTES];
  int checks;
  int errors;

  // Observations from the last run_req
  logic [63:0] obs_rdata, obs_wr_data;
  logic        obs_err, obs_both, obs_hold_ok;
  int          obs_rd_cyc, obs_wr_cyc, obs_resp_cyc, obs_rd_cnt, obs_wr_cnt;
  int          obs_rd_addr, obs_wr_addr, obs_rd_len, obs_wr_len;

  task automatic preload(input int idx, input logic [63:0] w);
    pre_en   = 1'b1;
    pre_idx  = idx[MA_W-1:0];
    pre_data = w;
    for (int i = 0; i < 8; i++) ref_bytes[idx*8+i] = w[8*i +: 8];
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Reference: byte-granular view of the access rules
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, output logic exp_err,
                              output logic [63:0] exp_rdata, output logic [63:0] exp_word);
    int sz;
    int a;
    logic [63:0] v;
    sz        = 1 << f3[1:0];
    exp_err   = ((addr % 64'(sz)) != 0) || (addr >= BYTES) || (!we && f3 == 3'b111) || (we && f3[2]);
    exp_rdata = '0;
    exp_word  = '0;
    if (exp_err) return;
    a = int'(addr);
    if (we) begin
      for (int i = 0; i < sz; i++) ref_bytes[a+i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_bytes[a+i];
      if (!f3[2] && sz < 8 && v[8*sz-1])
        for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
      exp_rdata = v;
    end
    for (int i = 0; i < 8; i++) exp_word[8*i +: 8] = ref_bytes[(a & ~7) + i];
  endtask

  // Drives one request, records what the DUT does relative to acceptance
  // (cycle 0), holds the response for 'hold' cycles, then accepts it.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int hold);
    int k;
    logic done;
    obs_rdata = '0; obs_wr_data = '0; obs_err = 1'b0; obs_both = 1'b0; obs_hold_ok = 1'b1;
    obs_rd_cyc = -1; obs_wr_cyc = -1; obs_resp_cyc = -1; obs_rd_cnt = 0; obs_wr_cnt = 0;
    obs_rd_addr = -1; obs_wr_addr = -1; obs_rd_len = -1; obs_wr_len = -1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.resp_ready = 1'b0;
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
      bus.req_valid = 1'b0;
      if (bus.mem_rd_en && bus.mem_wr_en) obs_both = 1'b1;
      if (bus.mem_rd_en) begin
        obs_rd_cnt++;
        if (obs_rd_cyc < 0) begin
          obs_rd_cyc = k; obs_rd_addr = int'(bus.mem_rd_addr); obs_rd_len = int'(bus.mem_rd_len);
        end
      end
      if (bus.mem_wr_en) begin
        obs_wr_cnt++;
        if (obs_wr_cyc < 0) begin
          obs_wr_cyc = k; obs_wr_addr = int'(bus.mem_wr_addr); obs_wr_len = int'(bus.mem_wr_len);
          obs_wr_data = bus.mem_wr_data;
        end
      end
      if (bus.resp_valid) begin
        obs_resp_cyc = k; obs_rdata = bus.resp_rdata; obs_err = bus.resp_err; done = 1'b1;
      end
    end
    if (done) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== obs_rdata || bus.resp_err !== obs_err ||
            bus.req_ready !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0)
          obs_hold_ok = 1'b0;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b011;
    bus.req_addr = 64'h8; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_ready got %b want 1", bus.req_ready); end
    checks++; if ({bus.resp_valid, bus.resp_err, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0) begin
      errors++; $display("[TB] FAIL rst_flags got %b want 0000", {bus.resp_valid, bus.resp_err, bus.mem_rd_en, bus.mem_wr_en}); end
    checks++; if ({bus.resp_rdata, bus.mem_wr_data} !== 128'b0) begin
      errors++; $display("[TB] FAIL rst_data got %h %h want 0", bus.resp_rdata, bus.mem_wr_data); end
    checks++; if ({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_rd_len, bus.mem_wr_len} !== 30'b0) begin
      errors++; $display("[TB] FAIL rst_addr_len got %h %h %h %h want 0", bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_rd_len, bus.mem_wr_len); end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.mem_rd_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_no_accept got rd=%b resp=%b want 0 0", bus.mem_rd_en, bus.resp_valid); end
    end
  endtask

  task automatic test_load_sign();
    preload(5, 64'h0000_0000_0000_8000);
    run_req(1'b0, 3'b000, 64'h29, 64'h0, 0);
    checks++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || obs_err !== 1'b0) begin
      errors++; $display("[TB] FAIL lb_result got %h err %b want ffffffffffffff80 err 0", obs_rdata, obs_err); end
    checks++; if (obs_rd_cyc != 1 || obs_resp_cyc != 3) begin
      errors++; $display("[TB] FAIL lb_timing got rd %0d resp %0d want 1 3", obs_rd_cyc, obs_resp_cyc); end
    checks++; if (obs_rd_addr != 5 || obs_rd_len != 1 || obs_wr_cnt != 0) begin
      errors++; $display("[TB] FAIL lb_port got addr %0d len %0d wr %0d want 5 1 0", obs_rd_addr, obs_rd_len, obs_wr_cnt); end
    run_req(1'b0, 3'b100, 64'h29, 64'h0, 0);
    checks++; if (obs_rdata !== 64'h80 || obs_err !== 1'b0) begin
      errors++; $display("[TB] FAIL lbu_result got %h err %b want 80 err 0", obs_rdata, obs_err); end
  endtask

  task automatic test_store_byte();
    logic e; logic [63:0] r, w;
    preload(2, 64'h1122_3344_5566_7788);
    model_access(1'b1, 3'b000, 64'h13, 64'hAB, e, r, w);
    run_req(1'b1, 3'b000, 64'h13, 64'hAB, 0);
    checks++; if (obs_rd_cyc != 1 || obs_wr_cyc != 3 || obs_resp_cyc != 4) begin
      errors++; $display("[TB] FAIL sb_timing got rd %0d wr %0d resp %0d want 1 3 4", obs_rd_cyc, obs_wr_cyc, obs_resp_cyc); end
    checks++; if (obs_wr_data !== 64'h1122_3344_AB66_7788) begin
      errors++; $display("[TB] FAIL sb_wr_data got %h want 11223344ab667788", obs_wr_data); end
    checks++; if (obs_wr_addr != 2 || obs_wr_len != 1 || obs_err !== 1'b0 || obs_rdata !== 64'h0) begin
      errors++; $display("[TB] FAIL sb_port got addr %0d len %0d err %b rdata %h want 2 1 0 0", obs_wr_addr, obs_wr_len, obs_err, obs_rdata); end
    run_req(1'b0, 3'b011, 64'h10, 64'h0, 0);
    checks++; if (obs_rdata !== 64'h1122_3344_AB66_7788 || obs_rd_len != 8) begin
      errors++; $display("[TB] FAIL sb_readback got %h len %0d want 11223344ab667788 8", obs_rdata, obs_rd_len); end
  endtask

  task automatic test_sd();
    logic e; logic [63:0] r, w;
    model_access(1'b1, 3'b011, 64'h3FF8, 64'hDEAD_BEEF_0BAD_F00D, e, r, w);
    run_req(1'b1, 3'b011, 64'h3FF8, 64'hDEAD_BEEF_0BAD_F00D, 0);
    checks++; if (obs_wr_cyc != 1 || obs_resp_cyc != 2 || obs_rd_cnt != 0) begin
      errors++; $display("[TB] FAIL sd_timing got wr %0d resp %0d rds %0d want 1 2 0", obs_wr_cyc, obs_resp_cyc, obs_rd_cnt); end
    checks++; if (obs_wr_addr != 2047 || obs_wr_data !== 64'hDEAD_BEEF_0BAD_F00D || obs_wr_len != 8) begin
      errors++; $display("[TB] FAIL sd_port got addr %0d data %h len %0d want 2047 deadbeef0badf00d 8", obs_wr_addr, obs_wr_data, obs_wr_len); end
  endtask

  task automatic test_errors();
    logic        we_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_t [4] = '{3'b010, 3'b011, 3'b111, 3'b100};
    logic [63:0] ad_t [4] = '{64'h102, 64'h4000, 64'h40, 64'h40};
    for (int i = 0; i < 4; i++) begin
      run_req(we_t[i], f3_t[i], ad_t[i], 64'hFFFF_0000_FFFF_0000, 0);
      checks++; if (obs_resp_cyc != 1 || obs_err !== 1'b1 || obs_rdata !== 64'h0) begin
        errors++; $display("[TB] FAIL err_case%0d got resp %0d err %b rdata %h want 1 1 0", i, obs_resp_cyc, obs_err, obs_rdata); end
      checks++; if (obs_rd_cnt != 0 || obs_wr_cnt != 0) begin
        errors++; $display("[TB] FAIL err_case%0d_mem got rd %0d wr %0d want 0 0", i, obs_rd_cnt, obs_wr_cnt); end
    end
  endtask

  task automatic test_backpressure();
    preload(4, 64'h1234_5678_FFFF_FFFF);
    run_req(1'b0, 3'b110, 64'h20, 64'h0, 5);
    checks++; if (obs_rdata !== 64'h0000_0000_FFFF_FFFF || obs_resp_cyc != 3) begin
      errors++; $display("[TB] FAIL bp_result got %h resp %0d want 00000000ffffffff 3", obs_rdata, obs_resp_cyc); end
    checks++; if (obs_hold_ok !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_hold got stable=%b want 1", obs_hold_ok); end
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release got ready %b resp %b want 1 0", bus.req_ready, bus.resp_valid); end
  endtask

  task automatic test_reset_mid_store();
    logic [63:0] w0;
    w0 = {$urandom, $urandom};
    preload(7, w0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 64'h3A; bus.req_wdata = 64'h5A5A; bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL rms_read got %b want 1", bus.mem_rd_en); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_wr_en !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rms_in_reset got wr %b resp %b ready %b want 0 0 1", bus.mem_wr_en, bus.resp_valid, bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_wr_en !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rms_after got wr %b resp %b ready %b want 0 0 1", bus.mem_wr_en, bus.resp_valid, bus.req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.mem_wr_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rms_idle got wr %b resp %b want 0 0", bus.mem_wr_en, bus.resp_valid); end
    end
    run_req(1'b0, 3'b011, 64'h38, 64'h0, 0);
    checks++; if (obs_rdata !== w0) begin errors++; $display("[TB] FAIL rms_readback got %h want %h", obs_rdata, w0); end
  endtask

  task automatic test_random();
    logic we; logic [2:0] f3; logic [63:0] addr, wdata, er, ew; logic ee;
    int sel, hold, exp_lat, exp_rd, exp_wr;
    for (int n = 0; n < 60; n++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = we ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      sel   = $urandom_range(0, 9);
      wdata = {$urandom, $urandom};
      hold  = $urandom_range(0, 2);
      if (sel == 0)      addr = 64'h4000 + 64'($urandom_range(0, 4095));
      else if (sel == 1) addr = 64'h3FF8 + 64'($urandom_range(0, 7));
      else               addr = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      model_access(we, f3, addr, wdata, ee, er, ew);
      exp_lat = ee ? 1 : (we ? ((f3[1:0] == 2'b11) ? 2 : 4) : 3);
      exp_rd  = (ee || (we && f3[1:0] == 2'b11)) ? 0 : 1;
      exp_wr  = (!ee && we) ? 1 : 0;
      run_req(we, f3, addr, wdata, hold);
      checks++; if (obs_err !== ee || obs_rdata !== er) begin
        errors++; $display("[TB] FAIL rnd%0d_resp got err %b rdata %h want err %b rdata %h", n, obs_err, obs_rdata, ee, er); end
      checks++; if (obs_resp_cyc != exp_lat || obs_rd_cnt != exp_rd || obs_wr_cnt != exp_wr) begin
        errors++; $display("[TB] FAIL rnd%0d_timing got lat %0d rd %0d wr %0d want %0d %0d %0d", n, obs_resp_cyc, obs_rd_cnt, obs_wr_cnt, exp_lat, exp_rd, exp_wr); end
      if (exp_wr == 1) begin
        checks++; if (obs_wr_data !== ew || obs_wr_addr != int'(addr >> 3)) begin
          errors++; $display("[TB] FAIL rnd%0d_write got %h @%0d want %h @%0d", n, obs_wr_data, obs_wr_addr, ew, addr >> 3); end
      end
      checks++; if (obs_both !== 1'b0 || obs_hold_ok !== 1'b1) begin
        errors++; $display("[TB] FAIL rnd%0d_ports got both %b stable %b want 0 1", n, obs_both, obs_hold_ok); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) preload(i, {$urandom, $urandom});
    test_reset();
    test_load_sign();
    test_store_byte();
    test_sd();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
